// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-16 Booth decode/accumulate datapath.
// Holds the controller state encoding, select bit positions and digit legality rule.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRECOMP = 2'd1,
        ACCUM   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int SEL_1X  = 0;
    localparam int SEL_3X  = 1;
    localparam int SEL_5X  = 2;
    localparam int SEL_7X  = 3;

    localparam int SHIFT_0 = 0;
    localparam int SHIFT_1 = 1;
    localparam int SHIFT_2 = 2;
    localparam int SHIFT_3 = 3;

    // A nonzero digit is legal only when its magnitude (multiple << shift) stays within 8.
    function automatic logic is_legal_digit(input logic [3:0] boothSel, input logic [3:0] shiftSel);
        logic legal;
        legal = 1'b0;
        case (boothSel)
            4'b0000: legal = 1'b1;
            4'b0001: legal = (shiftSel == 4'b0001) || (shiftSel == 4'b0010) ||
                             (shiftSel == 4'b0100) || (shiftSel == 4'b1000);
            4'b0010: legal = (shiftSel == 4'b0001) || (shiftSel == 4'b0010);
            4'b0100: legal = (shiftSel == 4'b0001);
            4'b1000: legal = (shiftSel == 4'b0001);
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Rebuilds one signed partial product from a Booth digit triplet and the
// precomputed odd multiples; illegal digits collapse to zero and raise a flag.
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+3:0]   multX,
    input  logic [WIDTH+3:0]   mult3X,
    input  logic [WIDTH+3:0]   mult5X,
    input  logic [WIDTH+3:0]   mult7X,
    input  logic               negative,
    input  logic [3:0]         boothSel,
    input  logic [3:0]         shiftSel,
    output logic [2*WIDTH-1:0] pp,
    output logic               illegal
);

    localparam int MW = WIDTH + 4;
    localparam int PW = 2 * WIDTH;

    logic [MW-1:0] multSel_s;
    logic [MW-1:0] shifted_s;
    logic [PW-1:0] ext_s;
    logic          legal_s;

    // Select multiple, apply shift, sign-extend and conditionally negate.
    always_comb begin
        legal_s   = is_legal_digit(boothSel, shiftSel);
        illegal   = ~legal_s;
        multSel_s = {MW{1'b0}};
        shifted_s = {MW{1'b0}};
        if (legal_s) begin
            case (1'b1)
                boothSel[SEL_1X]: multSel_s = multX;
                boothSel[SEL_3X]: multSel_s = mult3X;
                boothSel[SEL_5X]: multSel_s = mult5X;
                boothSel[SEL_7X]: multSel_s = mult7X;
                default:          multSel_s = {MW{1'b0}};
            endcase
        end else begin
            multSel_s = {MW{1'b0}};
        end
        // Legal shifts never push a magnitude past 8X, so MW bits hold every result.
        case (1'b1)
            shiftSel[SHIFT_0]: shifted_s = multSel_s;
            shiftSel[SHIFT_1]: shifted_s = multSel_s << 1;
            shiftSel[SHIFT_2]: shifted_s = multSel_s << 2;
            shiftSel[SHIFT_3]: shifted_s = multSel_s << 3;
            default:           shifted_s = {MW{1'b0}};
        endcase
        ext_s = {{(PW-MW){shifted_s[MW-1]}}, shifted_s};
        if (negative) begin
            pp = ~ext_s + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            pp = ext_s;
        end
    end

endmodule

// File: rtl/booth_decode_accum.sv
// Sequential radix-16 Booth decoder/accumulator: precomputes odd multiples,
// accumulates one weighted partial product per digit, and hands off the product.
module booth_decode_accum
    import booth_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NUM_DIGITS = 2
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iStart,
    input  logic [WIDTH-1:0]   iMcand,
    output logic               oBusy,
    input  logic               iDigValid,
    output logic               oDigReady,
    input  logic               iNegative,
    input  logic [3:0]         iBoothSel,
    input  logic [3:0]         iShiftSel,
    output logic               oValid,
    input  logic               iReady,
    output logic [2*WIDTH-1:0] oProduct,
    output logic               oErr
);

    localparam int MW = WIDTH + 4;
    localparam int PW = 2 * WIDTH;
    localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(NUM_DIGITS - 1);

    state_t        state_r, stateNext_s;
    logic [MW-1:0] multX_r, mult3X_r, mult5X_r, mult7X_r;
    logic [CW-1:0] digitCnt_r;
    logic [PW-1:0] accum_r;
    logic [PW-1:0] pp_s;
    logic          illegal_s;
    logic          digAccept_s;
    logic          startAccept_s;
    logic          busy_r, digReady_r, valid_r, err_r;

    assign digAccept_s   = iDigValid & digReady_r;
    assign startAccept_s = (state_r == IDLE) & iStart;

    booth_pp_gen #(.WIDTH(WIDTH)) ppGen (
        .multX    (multX_r),
        .mult3X   (mult3X_r),
        .mult5X   (mult5X_r),
        .mult7X   (mult7X_r),
        .negative (iNegative),
        .boothSel (iBoothSel),
        .shiftSel (iShiftSel),
        .pp       (pp_s),
        .illegal  (illegal_s)
    );

    // Next-state logic for the operation controller.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            IDLE:    if (iStart) stateNext_s = PRECOMP; else stateNext_s = IDLE;
            PRECOMP: stateNext_s = ACCUM;
            ACCUM:   if (digAccept_s && (digitCnt_r == LAST_DIGIT)) stateNext_s = DONE;
                     else stateNext_s = ACCUM;
            DONE:    if (iReady) stateNext_s = IDLE; else stateNext_s = DONE;
            default: stateNext_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_r <= IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Multiplicand latch and odd-multiple precompute.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            multX_r  <= {MW{1'b0}};
            mult3X_r <= {MW{1'b0}};
            mult5X_r <= {MW{1'b0}};
            mult7X_r <= {MW{1'b0}};
        end else if (startAccept_s) begin
            multX_r  <= {{(MW-WIDTH){iMcand[WIDTH-1]}}, iMcand};
        end else if (state_r == PRECOMP) begin
            mult3X_r <= multX_r + (multX_r << 1);
            mult5X_r <= multX_r + (multX_r << 2);
            mult7X_r <= (multX_r << 3) - multX_r;
        end else begin
            multX_r  <= multX_r;
        end
    end

    // Accumulator and digit counter; each digit k is weighted by 16^k.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            accum_r    <= {PW{1'b0}};
            digitCnt_r <= {CW{1'b0}};
        end else if (startAccept_s) begin
            accum_r    <= {PW{1'b0}};
            digitCnt_r <= {CW{1'b0}};
        end else if (digAccept_s) begin
            accum_r    <= accum_r + (pp_s << {digitCnt_r, 2'b00});
            digitCnt_r <= digitCnt_r + CW'(1);
        end else begin
            accum_r    <= accum_r;
        end
    end

    // Registered status flags, decoded from the upcoming state.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            busy_r     <= 1'b0;
            digReady_r <= 1'b0;
            valid_r    <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            busy_r     <= (stateNext_s != IDLE);
            digReady_r <= (stateNext_s == ACCUM);
            valid_r    <= (stateNext_s == DONE);
            err_r      <= digAccept_s & illegal_s;
        end
    end

    assign oBusy     = busy_r;
    assign oDigReady = digReady_r;
    assign oValid    = valid_r;
    assign oErr      = err_r;
    assign oProduct  = accum_r;

endmodule

// File: doc/booth_decode_accum.md
# booth_decode_accum

Sequential radix-16 Booth decoder and accumulator for the 8-bit fixed-point multiplier datapath. It consumes the per-digit select triplet produced by the Booth encoder (negative flag, one-hot odd-multiple select, one-hot shift select), least-significant digit first, together with a latched multiplicand. It rebuilds each signed partial product, weights it by 16^k and accumulates it. The finished 2·WIDTH-bit signed product is presented on a valid/ready output.

## Interface
- WIDTH, 8: multiplicand width, signed two's complement.
- NUM_DIGITS, 2: Booth digits per product (WIDTH/4).
- iClk  in  1  clock; all state updates on the rising edge.
- iRst  in  1  reset; synchronous, active-high.
- iStart  in  1  starts an operation; sampled only in IDLE.
- iMcand  in  WIDTH  signed multiplicand; latched on an accepted iStart.
- oBusy  out  1  high in every state except IDLE.
- iDigValid  in  1  digit triplet valid.
- oDigReady  out  1  high only in ACCUM.
- iNegative  in  1  digit sign.
- iBoothSel  in  4  one-hot multiple: bit0=1X, bit1=3X, bit2=5X, bit3=7X. 4'b0000 means digit zero.
- iShiftSel  in  4  one-hot left shift: bit n means shift by n.
- oValid  out  1  product valid.
- iReady  in  1  product accepted when oValid&iReady.
- oProduct  out  2·WIDTH  signed product; held stable while oValid is high.
- oErr  out  1  one-cycle pulse when an illegal digit is accepted.

## Operation
- States: IDLE, PRECOMP, ACCUM, DONE.
- IDLE→PRECOMP on iStart:
  - latch X=iMcand;
  - clear the accumulator and the digit counter.
- PRECOMP, one cycle:
  - register 3X=X+2X, 5X=X+4X, 7X=8X−X;
  - sign-extend each to WIDTH+4 bits;
  - then →ACCUM.
- ACCUM, per digit handshake (iDigValid&oDigReady):
  - form PP = ±(multiple<<shift);
  - add PP<<(4·k) to the accumulator, modulo 2^(2·WIDTH);
  - increment k.
  - →DONE on the edge that accepts digit NUM_DIGITS−1.
- DONE: oValid=1. On oValid&iReady →IDLE.
- Zero digit: iBoothSel=0000 gives PP=0. iNegative and iShiftSel are ignored.
- Legal nonzero digit (magnitude ≤ 8), all others illegal:
  - 1X with shift 0..3;
  - 3X with shift 0..1;
  - 5X with shift 0;
  - 7X with shift 0.
- Illegal digit (either select non-one-hot, or a shift outside the legal set):
  - the digit is consumed and counted;
  - PP=0;
  - oErr pulses the cycle after acceptance.
- Negation is two's complement (invert plus carry-in); −(8·−128) is representable.
- iStart outside IDLE is ignored, including DONE with iReady high.

## Timing
- Reset values: oBusy=0, oDigReady=0, oValid=0, oProduct=0, oErr=0. State=IDLE, accumulator=0, k=0.
- Reset mid-operation abandons the product; nothing is emitted.
- Handshakes:
  - iStart accepted at edge t: PRECOMP in cycle t+1, oDigReady=1 from cycle t+2;
  - back-to-back digits are accepted one per cycle; iDigValid low inserts stalls with no state loss;
  - oValid rises the cycle after the last digit is accepted;
  - oProduct equals the accumulator registered value and does not change while oValid is high;
  - minimum start-to-oValid is 2+NUM_DIGITS cycles;
  - output acceptance at edge t gives IDLE in cycle t+1, and a new iStart can be accepted at that edge.
- oDigReady and oValid are never high together.

## Structure
- Package booth_pkg holds:
  - state enum typedef;
  - BoothSel/ShiftSel bit-position constants;
  - function is_legal_digit(boothsel, shiftsel).
- Combinational sub-module booth_pp_gen:
  - inputs: registered X, 3X, 5X, 7X and the digit triplet;
  - outputs: the sign-extended PP and the illegal flag.
- Top module: FSM, multiple registers, digit counter, accumulator and output register.

## Test plan
- X=13, digits {neg0, 1X, <<2} then {neg0, 3X, <<1} (multiplier 100) → oProduct=0x0514 (1300); oErr never high.
- X=−7 (0xF9), digits {zero} then {neg1, 1X, <<3} (multiplier −128) → oProduct=0x0380 (896).
- X=−128, digits {zero} then {neg1, 1X, <<3} → oProduct=0x4000. Exercises the extreme negate.
- Illegal digit {neg0, 3X, <<3} as digit 0, then {neg0, 1X, <<0}:
  - oErr pulses exactly once;
  - with X=5, oProduct=80.
- Backpressure:
  - iReady low for 5 cycles: oProduct stable, oDigReady=0, iStart pulses ignored;
  - iDigValid gaps of 3 cycles between digits give the same product as back-to-back digits.
- iRst asserted mid-ACCUM after digit 0:
  - next cycle all outputs are 0 and the state is IDLE;
  - a fresh X=13 / multiplier-100 run yields 0x0514.
